// File: rtl/shift_amount_gen_pkg.sv
// shift_amount_gen_pkg: FSM state encoding and shift-direction constants shared by
// the normalization shift-amount generator and the shifter control FSM.
package shift_amount_gen_pkg;
    typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;
endpackage

// File: rtl/shift_amount_gen_lzd_group.sv
// lzd_group: combinational leading-zero count over one GW-bit group (MSB first),
// with an all-zero flag.
module lzd_group #(
    parameter int GW = 4,
    parameter int EW = 8
) (
    input  logic [GW-1:0] group,
    output logic          zero,
    output logic [EW-1:0] count
);
    logic hit;
    assign zero = ~|group;
    always_comb begin
        hit   = 1'b0;
        count = '0;
        for (int i = GW - 1; i >= 0; i--) begin
            hit   = hit | group[i];
            count = count + EW'(!hit);
        end
    end
endmodule

// File: rtl/shift_amount_gen.sv
// shift_amount_gen: multi-cycle normalization shift-amount generator; scans the
// mantissa GW bits per cycle for the leading one and reports shift, direction, zero.
module shift_amount_gen
    import shift_amount_gen_pkg::*;
#(
    parameter int SW = 32,
    parameter int EW = 8,
    parameter int GW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [SW-1:0] Data_i,
    output logic          busy_o,
    output logic          ready_o,
    output logic [EW-1:0] Shift_Value_o,
    output logic          FSM_left_right_o,
    output logic          zero_o
);
    state_t           state;
    logic [SW-1:0]    work;
    logic [EW-1:0]    count;
    logic [SW+GW-2:0] ext;
    logic [GW-1:0]    group;
    logic             group_zero;
    logic [EW-1:0]    group_count;

    // Zero-pad below bit 0 so a final partial group is still GW bits wide.
    assign ext   = {work[SW-2:0], GW'(0)};
    assign group = ext[SW+GW-2 -: GW];

    lzd_group #(.GW(GW), .EW(EW)) u_lzd (
        .group (group),
        .zero  (group_zero),
        .count (group_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            work             <= '0;
            count            <= '0;
            busy_o           <= 1'b0;
            ready_o          <= 1'b0;
            Shift_Value_o    <= '0;
            FSM_left_right_o <= 1'b0;
            zero_o           <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    work   <= Data_i;
                    count  <= '0;
                    busy_o <= 1'b1;
                    state  <= CHECK;
                end
                CHECK: if (work[SW-1]) begin
                    Shift_Value_o    <= EW'(1);
                    FSM_left_right_o <= DIR_RIGHT;
                    zero_o           <= 1'b0;
                    ready_o          <= 1'b1;
                    state            <= DONE;
                end else if (work[SW-2:0] == '0) begin
                    Shift_Value_o    <= '0;
                    FSM_left_right_o <= DIR_LEFT;
                    zero_o           <= 1'b1;
                    ready_o          <= 1'b1;
                    state            <= DONE;
                end else begin
                    state <= SCAN;
                end
                SCAN: if (group_zero) begin
                    count <= count + EW'(GW);
                    work  <= {1'b0, work[SW-2:0] << GW};
                end else begin
                    Shift_Value_o    <= count + group_count;
                    FSM_left_right_o <= DIR_LEFT;
                    zero_o           <= 1'b0;
                    ready_o          <= 1'b1;
                    state            <= DONE;
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_amount_gen.sv
// tb_shift_amount_gen: scoreboard bench; stimulus pushes model expectations, a
// negedge monitor pops and compares on every ready_o pulse.
module tb_shift_amount_gen;
    localparam int SW = 32;
    localparam int EW = 8;
    localparam int GW = 4;

    typedef struct {
        int lat;
        int sh;
        bit dir;
        bit zero;
        int acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [SW-1:0] Data_i = '0;
    logic          busy_o, ready_o, FSM_left_right_o, zero_o;
    logic [EW-1:0] Shift_Value_o;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];
    logic [EW-1:0] last_shift = '0;

    shift_amount_gen #(.SW(SW), .EW(EW), .GW(GW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .Data_i           (Data_i),
        .busy_o           (busy_o),
        .ready_o          (ready_o),
        .Shift_Value_o    (Shift_Value_o),
        .FSM_left_right_o (FSM_left_right_o),
        .zero_o           (zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: find the leading one arithmetically; scans = groups needed to reach it.
    function automatic exp_t model(input logic [SW-1:0] d);
        exp_t e;
        int p;
        e.acc = 0;
        if (d[SW-1]) begin
            e.lat = 2; e.sh = 1; e.dir = 1'b0; e.zero = 1'b0;
        end else if (d == '0) begin
            e.lat = 2; e.sh = 0; e.dir = 1'b1; e.zero = 1'b1;
        end else begin
            p = SW - 2;
            while (!d[p]) p--;
            e.sh = (SW - 2) - p;
            e.lat = 2 + e.sh / GW + 1;
            e.dir = 1'b1; e.zero = 1'b0;
        end
        return e;
    endfunction

    // Latency counts edges from accept to the edge at which ready_o is sampled high.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_shift = '0;
        end else if (ready_o) begin
            if (q.size() == 0) begin
                chk("unexpected_ready", 1, 0);
            end else begin
                e = q.pop_front();
                chk("shift", int'(Shift_Value_o), e.sh);
                chk("dir", int'(FSM_left_right_o), int'(e.dir));
                chk("zero", int'(zero_o), int'(e.zero));
                chk("latency", cyc - e.acc + 1, e.lat);
                chk("busy_in_done", int'(busy_o), 1);
            end
            last_shift = Shift_Value_o;
        end else begin
            chk("shift_hold", int'(Shift_Value_o), int'(last_shift));
        end
    end

    task automatic wait_idle;
        int n = 0;
        @(negedge clk);
        while (busy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) chk("idle_timeout", 1, 0);
    endtask

    task automatic launch(input logic [SW-1:0] d);
        exp_t e;
        wait_idle();
        start_i = 1'b1;
        Data_i  = d;
        @(posedge clk);
        #1;
        e = model(d);
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic do_op(input logic [SW-1:0] d, input bit hold);
        int n = 0;
        launch(d);
        if (hold) begin
            do begin
                @(negedge clk);
                Data_i = $urandom;
                n++;
            end while (!ready_o && n < 50);
        end else begin
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_shift", int'(Shift_Value_o), 0);
        chk("rst_dir", int'(FSM_left_right_o), 0);
        chk("rst_zero", int'(zero_o), 0);
        rst = 1'b0;
        do_op(32'h0000_1000, 1'b0);
        do_op(32'h8000_0000, 1'b0);
        do_op(32'h4000_0000, 1'b0);
        do_op(32'h0000_0001, 1'b0);
        do_op(32'h0000_0000, 1'b0);
        do_op(32'h0000_1000, 1'b1);
        do_op(32'h0001_0000, 1'b0);
        // Abort mid-SCAN: outputs clear at once and the pending result is dropped.
        launch(32'h0000_0001);
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q.delete();
        #1;
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_ready", int'(ready_o), 0);
        chk("abort_shift", int'(Shift_Value_o), 0);
        chk("abort_dir", int'(FSM_left_right_o), 0);
        chk("abort_zero", int'(zero_o), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_abort_idle", int'(busy_o), 0);
        do_op(32'h0000_1000, 1'b0);
        for (int i = 0; i < 40; i++)
            do_op($urandom >> $urandom_range(0, 32), i % 7 == 3);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
